// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V core front end.
package riscv_pkg;

    localparam int          XLEN       = 32;
    localparam int          ADDR_WIDTH = XLEN;
    localparam int          INSTR_WIDTH = XLEN;
    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } fetch_state_t;

    // Instruction fetches are word aligned; drop the byte offset.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_register.sv
// Enabled register with asynchronous active-low reset; used for the PC and IF/ID fields.
module pc_register #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch: owns the PC, addresses the combinational ROM and fills the IF/ID register.
module instruction_fetch_stage
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH   = riscv_pkg::XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = riscv_pkg::RESET_PC,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] fetch_addr_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_o,
    output logic [DATA_WIDTH-1:0] if_id_pc4_o,
    output logic                  if_id_valid_o,
    output logic                  fetch_fault_o
);

    localparam logic [31:0] DEPTH = MEMORY_DEPTH;

    fetch_state_t state, state_next;

    logic [DATA_WIDTH-1:0] pc, pc_plus4, pc_next;
    logic [DATA_WIDTH-1:0] instr_next, ifid_pc_next, ifid_pc4_next;
    logic                  valid_next, in_window, advance, fault_set;
    logic [31:0]           word_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_RESET;
        else
            state <= state_next;
    end

    // RUN is the only operating state; stall and redirect qualify it.
    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_RESET;
        endcase
    end

    assign pc_plus4  = pc + DATA_WIDTH'(4);
    assign word_idx  = {17'd0, pc[16:2]};
    assign in_window = (word_idx < DEPTH);
    assign advance   = redirect_i | ~stall_i;

    always_comb begin
        pc_next       = pc_plus4;
        instr_next    = in_window ? Instruction_i : NOP_INSTR;
        ifid_pc_next  = pc;
        ifid_pc4_next = pc_plus4;
        valid_next    = in_window;
        fault_set     = ~stall_i & ~in_window;
        if (redirect_i) begin
            pc_next       = word_align(redirect_target_i);
            instr_next    = NOP_INSTR;
            ifid_pc_next  = '0;
            ifid_pc4_next = '0;
            valid_next    = 1'b0;
            fault_set     = |redirect_target_i[1:0];
        end
    end

    pc_register #(.WIDTH(DATA_WIDTH), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst_n(reset), .en(advance), .d(pc_next), .q(pc)
    );

    pc_register #(.WIDTH(DATA_WIDTH), .RESET_VAL(NOP_INSTR)) u_ifid_instr (
        .clk(clk), .rst_n(reset), .en(advance), .d(instr_next), .q(if_id_instr_o)
    );

    pc_register #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_ifid_pc (
        .clk(clk), .rst_n(reset), .en(advance), .d(ifid_pc_next), .q(if_id_pc_o)
    );

    pc_register #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_ifid_pc4 (
        .clk(clk), .rst_n(reset), .en(advance), .d(ifid_pc4_next), .q(if_id_pc4_o)
    );

    pc_register #(.WIDTH(1), .RESET_VAL(1'b0)) u_ifid_valid (
        .clk(clk), .rst_n(reset), .en(advance), .d(valid_next), .q(if_id_valid_o)
    );

    // Sticky: once set only reset clears it.
    pc_register #(.WIDTH(1), .RESET_VAL(1'b0)) u_fault (
        .clk(clk), .rst_n(reset), .en(fault_set), .d(1'b1), .q(fetch_fault_o)
    );

    assign fetch_addr_o = pc;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a simple address-derived ROM model.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, redirect;
    logic [31:0] target;
    logic [31:0] rom_data, fetch_addr, instr, pc, pc4;
    logic        valid, fault;

    logic        stall4 = 1'b0, redirect4 = 1'b0;
    logic [31:0] target4 = 32'd0;
    logic [31:0] rom_data4, fetch_addr4, instr4, pc_4, pc4_4;
    logic        valid4, fault4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rom_data  = {16'hC0DE, fetch_addr[15:0]};
    assign rom_data4 = {16'hC0DE, fetch_addr4[15:0]};

    instruction_fetch_stage dut (
        .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
        .redirect_target_i(target), .Instruction_i(rom_data),
        .fetch_addr_o(fetch_addr), .if_id_instr_o(instr), .if_id_pc_o(pc),
        .if_id_pc4_o(pc4), .if_id_valid_o(valid), .fetch_fault_o(fault)
    );

    instruction_fetch_stage #(.MEMORY_DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .stall_i(stall4), .redirect_i(redirect4),
        .redirect_target_i(target4), .Instruction_i(rom_data4),
        .fetch_addr_o(fetch_addr4), .if_id_instr_o(instr4), .if_id_pc_o(pc_4),
        .if_id_pc4_o(pc4_4), .if_id_valid_o(valid4), .fetch_fault_o(fault4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_fetch, input logic [31:0] e_instr,
                            input logic [31:0] e_pc, input logic [31:0] e_pc4, input logic e_valid);
        chk({tag, ".fetch"}, fetch_addr, e_fetch);
        chk({tag, ".instr"}, instr, e_instr);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".pc4"}, pc4, e_pc4);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; target = 32'd0;
        tick(); tick();
        chk_ifid("rst", 32'h0040_0000, NOP, 32'd0, 32'd0, 1'b0);
        chk("rst.fault", {31'd0, fault}, 32'd0);

        // 1: release and run
        reset = 1'b1;
        #1;
        chk("run0.fetch", fetch_addr, 32'h0040_0000);
        chk("run0.valid", {31'd0, valid}, 32'd0);
        tick();
        chk_ifid("run1", 32'h0040_0004, 32'hC0DE_0000, 32'h0040_0000, 32'h0040_0004, 1'b1);
        tick();
        chk_ifid("run2", 32'h0040_0008, 32'hC0DE_0004, 32'h0040_0004, 32'h0040_0008, 1'b1);

        // 2: three-cycle stall; the depth-4 instance runs on unstalled alongside
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("stall", 32'h0040_0008, 32'hC0DE_0004, 32'h0040_0004, 32'h0040_0008, 1'b1);
            if (i == 1) begin
                chk("d4.last.fetch", fetch_addr4, 32'h0040_0010);
                chk("d4.last.pc", pc_4, 32'h0040_000C);
                chk("d4.last.valid", {31'd0, valid4}, 32'd1);
                chk("d4.last.fault", {31'd0, fault4}, 32'd0);
            end
            if (i == 2) begin
                chk("d4.out.instr", instr4, NOP);
                chk("d4.out.valid", {31'd0, valid4}, 32'd0);
                chk("d4.out.fault", {31'd0, fault4}, 32'd1);
                chk("d4.out.fetch", fetch_addr4, 32'h0040_0014);
            end
        end
        stall = 1'b0;
        tick();
        chk_ifid("resume", 32'h0040_000C, 32'hC0DE_0008, 32'h0040_0008, 32'h0040_000C, 1'b1);

        // 3: redirect wins over simultaneous stall
        stall = 1'b1; redirect = 1'b1; target = 32'h0040_0040;
        tick();
        chk_ifid("redir", 32'h0040_0040, NOP, 32'd0, 32'd0, 1'b0);
        chk("redir.fault", {31'd0, fault}, 32'd0);
        stall = 1'b0; redirect = 1'b0;
        tick();
        chk_ifid("redir+1", 32'h0040_0044, 32'hC0DE_0040, 32'h0040_0040, 32'h0040_0044, 1'b1);

        // 4: misaligned redirect aligns the PC and latches the fault
        redirect = 1'b1; target = 32'h0040_0042;
        tick();
        chk("mis.fetch", fetch_addr, 32'h0040_0040);
        chk("mis.fault", {31'd0, fault}, 32'd1);
        redirect = 1'b0;
        tick();
        chk("mis+1.pc", pc, 32'h0040_0040);
        chk("mis+1.fault", {31'd0, fault}, 32'd1);
        tick();
        chk("mis+2.fault", {31'd0, fault}, 32'd1);

        // 6: asynchronous reset mid-stream
        redirect = 1'b1; target = 32'h0040_0020;
        tick();
        redirect = 1'b0;
        chk("pre.fetch", fetch_addr, 32'h0040_0020);
        #2 reset = 1'b0;
        #1;
        chk_ifid("async", 32'h0040_0000, NOP, 32'd0, 32'd0, 1'b0);
        chk("async.fault", {31'd0, fault}, 32'd0);
        tick();
        chk("hold.fetch", fetch_addr, 32'h0040_0000);

        // PC+4 wraps past the top of the address space
        reset = 1'b1;
        redirect = 1'b1; target = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap0.fetch", fetch_addr, 32'hFFFF_FFFC);
        tick();
        chk_ifid("wrap1", 32'd0, NOP, 32'hFFFF_FFFC, 32'd0, 1'b0);
        chk("wrap1.fault", {31'd0, fault}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
